// File: rtl/axi_4_slave_burst_ctrl_if.sv
// AXI4 channel bundle between the vector processor's master controller and the
// burst slave. Address, data and response channels only; clock/reset stay separate.
interface axi_4_slave_burst_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  m_arvalid;
   logic                  s_arready;
   logic [ADDR_W-1:0]     m_araddr;
   logic [7:0]            m_arlen;
   logic [1:0]            m_arburst;

   logic                  s_rvalid;
   logic                  m_rready;
   logic [DATA_W-1:0]     s_rdata;
   logic [1:0]            s_rresp;
   logic                  s_rlast;

   logic                  m_awvalid;
   logic                  s_awready;
   logic [ADDR_W-1:0]     m_awaddr;
   logic [7:0]            m_awlen;
   logic [1:0]            m_awburst;

   logic                  m_wvalid;
   logic                  s_wready;
   logic [DATA_W-1:0]     m_wdata;
   logic [DATA_W/8-1:0]   m_wstrb;
   logic                  m_wlast;

   logic                  s_bvalid;
   logic                  m_bready;
   logic [1:0]            s_bresp;

   modport slave (
      input  m_arvalid, m_araddr, m_arlen, m_arburst,
      input  m_rready,
      input  m_awvalid, m_awaddr, m_awlen, m_awburst,
      input  m_wvalid, m_wdata, m_wstrb, m_wlast,
      input  m_bready,
      output s_arready, s_rvalid, s_rdata, s_rresp, s_rlast,
      output s_awready, s_wready, s_bvalid, s_bresp
   );

   modport master (
      output m_arvalid, m_araddr, m_arlen, m_arburst,
      output m_rready,
      output m_awvalid, m_awaddr, m_awlen, m_awburst,
      output m_wvalid, m_wdata, m_wstrb, m_wlast,
      output m_bready,
      input  s_arready, s_rvalid, s_rdata, s_rresp, s_rlast,
      input  s_awready, s_wready, s_bvalid, s_bresp
   );
endinterface

// File: rtl/axi_4_slave_burst_ctrl.sv
// AXI4 slave burst controller: one burst in flight, FIXED/INCR/WRAP address
// generation, range/WLAST checking and round-robin AR/AW arbitration onto a single-port memory.
module axi_4_slave_burst_ctrl #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MEM_BYTES = 4096,
   parameter int MEM_LAT   = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   axi_4_slave_burst_ctrl_if.slave axi,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [DATA_W/8-1:0]   mem_wstrb,
   input  logic [DATA_W-1:0]     mem_rdata
);
   localparam int BYTES = DATA_W / 8;
   localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [ADDR_W-1:0] MEM_LIMIT  = ADDR_W'(MEM_BYTES);
   localparam logic [ADDR_W-1:0] BYTES_A    = ADDR_W'(BYTES);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES - 1);
   localparam logic [LAT_W-1:0]  LAT_LAST   = LAT_W'(MEM_LAT - 1);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      RD_ISSUE,
      RD_WAIT,
      RD_RESP,
      WR_DATA,
      WR_RESP
   } state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [7:0]         len_q, len_d;
   logic [1:0]         burst_q, burst_d;
   logic [7:0]         beat_q, beat_d;
   logic               err_q, err_d;
   logic               bad_q, bad_d;
   logic               prio_rd_q, prio_rd_d;
   logic [LAT_W-1:0]   lat_q, lat_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;
   logic [1:0]         rresp_q, rresp_d;
   logic               rlast_q, rlast_d;

   logic               ar_rdy, aw_rdy, w_rdy, r_vld, b_vld;
   logic               mem_en_c, mem_we_c;
   logic [ADDR_W-1:0]  wrap_mask, incr_addr, next_addr;
   logic               beat_err, last_beat;

   // WRAP lengths are restricted to 2/4/8/16 beats on an aligned start address.
   function automatic logic illegal_burst(input logic [1:0] b, input logic [7:0] l,
                                          input logic [ADDR_W-1:0] a);
      logic bad_len;
      bad_len = (l != 8'd1) && (l != 8'd3) && (l != 8'd7) && (l != 8'd15);
      return (b == 2'b11) ||
             ((b == BURST_WRAP) && (bad_len || ((a & ALIGN_MASK) != '0)));
   endfunction

   always_comb begin
      wrap_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) * BYTES_A) - ADDR_W'(1);
      incr_addr = addr_q + BYTES_A;
      case (burst_q)
         BURST_INCR: next_addr = incr_addr;
         BURST_WRAP: next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
         default:    next_addr = addr_q;
      endcase
      beat_err  = bad_q || (addr_q >= MEM_LIMIT);
      last_beat = (beat_q == len_q);
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      len_d     = len_q;
      burst_d   = burst_q;
      beat_d    = beat_q;
      err_d     = err_q;
      bad_d     = bad_q;
      prio_rd_d = prio_rd_q;
      lat_d     = lat_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      rlast_d   = rlast_q;
      ar_rdy    = 1'b0;
      aw_rdy    = 1'b0;
      w_rdy     = 1'b0;
      r_vld     = 1'b0;
      b_vld     = 1'b0;
      mem_en_c  = 1'b0;
      mem_we_c  = 1'b0;

      case (state_q)
         IDLE: begin
            ar_rdy = !axi.m_awvalid || prio_rd_q;
            aw_rdy = !axi.m_arvalid || !prio_rd_q;
            if (axi.m_arvalid && ar_rdy) begin
               addr_d    = axi.m_araddr;
               len_d     = axi.m_arlen;
               burst_d   = axi.m_arburst;
               bad_d     = illegal_burst(axi.m_arburst, axi.m_arlen, axi.m_araddr);
               beat_d    = 8'd0;
               err_d     = 1'b0;
               prio_rd_d = 1'b0;
               state_d   = RD_ISSUE;
            end else if (axi.m_awvalid && aw_rdy) begin
               addr_d    = axi.m_awaddr;
               len_d     = axi.m_awlen;
               burst_d   = axi.m_awburst;
               bad_d     = illegal_burst(axi.m_awburst, axi.m_awlen, axi.m_awaddr);
               beat_d    = 8'd0;
               err_d     = 1'b0;
               prio_rd_d = 1'b1;
               state_d   = WR_DATA;
            end
         end
         RD_ISSUE: begin
            mem_en_c = !beat_err;
            lat_d    = '0;
            state_d  = RD_WAIT;
         end
         RD_WAIT: begin
            if (lat_q == LAT_LAST) begin
               rdata_d = beat_err ? '0 : mem_rdata;
               rresp_d = beat_err ? RESP_SLVERR : RESP_OKAY;
               rlast_d = last_beat;
               state_d = RD_RESP;
            end else begin
               lat_d = lat_q + LAT_W'(1);
            end
         end
         RD_RESP: begin
            r_vld = 1'b1;
            if (axi.m_rready) begin
               if (rlast_q) begin
                  state_d = IDLE;
               end else begin
                  addr_d  = next_addr;
                  beat_d  = beat_q + 8'd1;
                  state_d = RD_ISSUE;
               end
            end
         end
         WR_DATA: begin
            w_rdy = 1'b1;
            if (axi.m_wvalid) begin
               mem_en_c = !beat_err;
               mem_we_c = !beat_err;
               err_d    = err_q || beat_err || (axi.m_wlast != last_beat);
               if (last_beat) begin
                  state_d = WR_RESP;
               end else begin
                  addr_d = next_addr;
                  beat_d = beat_q + 8'd1;
               end
            end
         end
         WR_RESP: begin
            b_vld = 1'b1;
            if (axi.m_bready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Nothing may handshake or touch memory while reset is being sampled.
      if (reset) begin
         ar_rdy   = 1'b0;
         aw_rdy   = 1'b0;
         w_rdy    = 1'b0;
         r_vld    = 1'b0;
         b_vld    = 1'b0;
         mem_en_c = 1'b0;
         mem_we_c = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         len_q     <= '0;
         burst_q   <= '0;
         beat_q    <= '0;
         err_q     <= 1'b0;
         bad_q     <= 1'b0;
         prio_rd_q <= 1'b1;
         lat_q     <= '0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
         rlast_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         burst_q   <= burst_d;
         beat_q    <= beat_d;
         err_q     <= err_d;
         bad_q     <= bad_d;
         prio_rd_q <= prio_rd_d;
         lat_q     <= lat_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         rlast_q   <= rlast_d;
      end
   end

   assign axi.s_arready = ar_rdy;
   assign axi.s_awready = aw_rdy;
   assign axi.s_wready  = w_rdy;
   assign axi.s_rvalid  = r_vld;
   assign axi.s_bvalid  = b_vld;
   assign axi.s_rdata   = rdata_q;
   assign axi.s_rresp   = rresp_q;
   assign axi.s_rlast   = rlast_q && (state_q == RD_RESP);
   assign axi.s_bresp   = ((state_q == WR_RESP) && err_q) ? RESP_SLVERR : RESP_OKAY;

   assign mem_en    = mem_en_c;
   assign mem_we    = mem_we_c;
   assign mem_addr  = addr_q;
   assign mem_wdata = axi.m_wdata;
   assign mem_wstrb = axi.m_wstrb;
endmodule

// File: doc/axi_4_slave_burst_ctrl.md
Name: axi_4_slave_burst_ctrl

Overview:
Parametrised AXI4 slave controller. It terminates all five AXI4 channels and drives a single-port synchronous memory. Unlike the previous generation, it owns the datapath: it captures addresses, counts beats, generates FIXED/INCR/WRAP burst addresses, checks address range and WLAST, returns OKAY/SLVERR, and arbitrates simultaneous read and write requests round-robin. It sits between the vector processor's AXI4 master controller and the data memory.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data width in bits (power of two, >=8); BYTES = DATA_W/8
MEM_BYTES, 4096, legal address range is 0..MEM_BYTES-1
MEM_LAT, 1, cycles from mem_en (read) to valid mem_rdata, >=1

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
m_arvalid  in  1  read address valid
s_arready  out  1  read address ready
m_araddr  in  ADDR_W  read start address
m_arlen  in  8  read beats-1
m_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
s_rvalid  out  1  read data valid
m_rready  in  1  master accepts read beat
s_rdata  out  DATA_W  read data
s_rresp  out  2  00 OKAY, 10 SLVERR
s_rlast  out  1  final read beat
m_awvalid  in  1  write address valid
s_awready  out  1  write address ready
m_awaddr  in  ADDR_W  write start address
m_awlen  in  8  write beats-1
m_awburst  in  2  as m_arburst
m_wvalid  in  1  write data valid
s_wready  out  1  write data ready
m_wdata  in  DATA_W  write data
m_wstrb  in  BYTES  byte strobes
m_wlast  in  1  master's last-beat flag
s_bvalid  out  1  write response valid
m_bready  in  1  master accepts response
s_bresp  out  2  00 OKAY, 10 SLVERR
mem_en  out  1  memory access strobe
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  beat address
mem_wdata  out  DATA_W  write data (passthrough of m_wdata)
mem_wstrb  out  BYTES  write strobes (passthrough of m_wstrb)
mem_rdata  in  DATA_W  read data, valid MEM_LAT cycles after mem_en

Behaviour:
- Reset (sync, high): state IDLE; all valid/ready outputs, mem_en, mem_we, s_rlast = 0; s_rdata, s_rresp, s_bresp = 0; round-robin flag prio_rd = 1. Reset mid-burst aborts at once; no R or B beat is emitted for the aborted burst.
- FSM states: IDLE, RD_ISSUE, RD_WAIT, RD_RESP, WR_DATA, WR_RESP. One burst is in flight at a time.
- IDLE: s_arready = !m_awvalid || prio_rd; s_awready = !m_arvalid || !prio_rd. On a handshake: capture addr, len, burst; clear beat counter and error flag; flip prio_rd to favour the other channel. AR goes to RD_ISSUE, AW goes to WR_DATA.
- Address generation: FIXED keeps the start address. INCR adds BYTES per beat. WRAP requires len in {1,3,7,15} and an address aligned to BYTES; the wrap boundary is (len+1)*BYTES.
- Illegal bursts: burst=11, an illegal WRAP len, or a misaligned WRAP make the whole burst an error burst. It performs no memory access; every beat is SLVERR with rdata 0.
- Range check: a beat with address >= MEM_BYTES gets SLVERR, and mem_en is suppressed for that beat.
- Read path:
  - RD_ISSUE: mem_en=1, mem_we=0 for 1 cycle.
  - RD_WAIT: counts MEM_LAT cycles, then registers mem_rdata.
  - RD_RESP: s_rvalid=1; s_rdata, s_rresp, s_rlast stay stable until m_rready. On handshake, the last beat goes to IDLE; otherwise advance address and go to RD_ISSUE.
  - Timing: AR handshake to first s_rvalid is MEM_LAT+2 cycles; one beat per MEM_LAT+2 cycles with m_rready held high.
- Write path:
  - WR_DATA: s_wready=1 from the cycle after the AW handshake. On W handshake, mem_en = mem_we = 1 in the same cycle (combinational), with mem_addr = current beat address, unless the beat is errored.
  - The burst ends on beat counter == len.
  - m_wlast high before the final beat, or low on it, sets the error flag.
  - WR_RESP: s_bvalid=1 held until m_bready, then IDLE. s_bresp = SLVERR if any beat erred, else OKAY.
- The beat counter is 8 bits; len=255 gives 256 beats with no overflow.

Test Plan:
- AR addr 0x100, len 3, INCR, m_rready=1, MEM_LAT=1 -> mem_addr 0x100/104/108/10C; first s_rvalid 3 cycles after AR; s_rlast on beat 4 only; rresp OKAY.
- AR addr 0x38, len 3, WRAP -> mem_addr 0x38, 0x3C, 0x30, 0x34.
- AW addr 0xFF8, len 3, INCR, strb 0xF -> writes at 0xFF8 and 0xFFC only; mem_en low for 0x1000 and 0x1004; bresp SLVERR.
- m_arvalid and m_awvalid asserted together twice from reset -> read granted first, write second; while AR is granted s_awready=0.
- During a read burst, m_rready low for 5 cycles -> s_rvalid, s_rdata, s_rlast stay stable; no extra mem_en.
- AW len 1 with m_wlast on beat 1 -> bresp SLVERR. Separately, reset asserted mid-burst -> next cycle IDLE with all outputs 0.
